// File: rtl/efb_wb_arbiter.sv
// Two-master Wishbone arbiter in front of the 8-bit EFB slave port.
// Grants are held for a master's whole cyc assertion; a stalled-ack watchdog frees the bus.
module efb_wb_arbiter #(
  parameter string       PRIORITY = "RR",
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned TO_WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m0_cyc_i,
  input  logic       m0_stb_i,
  input  logic       m0_we_i,
  input  logic [7:0] m0_adr_i,
  input  logic [7:0] m0_dat_i,
  output logic [7:0] m0_dat_o,
  output logic       m0_ack_o,
  output logic       m0_err_o,
  input  logic       m1_cyc_i,
  input  logic       m1_stb_i,
  input  logic       m1_we_i,
  input  logic [7:0] m1_adr_i,
  input  logic [7:0] m1_dat_i,
  output logic [7:0] m1_dat_o,
  output logic       m1_ack_o,
  output logic       m1_err_o,
  output logic       s_cyc_o,
  output logic       s_stb_o,
  output logic       s_we_o,
  output logic [7:0] s_adr_o,
  output logic [7:0] s_dat_o,
  input  logic [7:0] s_dat_i,
  input  logic       s_ack_i,
  output logic [1:0] grant_o,
  output logic       timeout_o,
  output logic [1:0] dbg_state_o
);

  // Handshake: a transfer completes in the cycle where the owner has cyc&stb high and the
  // slave returns ack; err replaces ack only when the watchdog expires without an ack.

  typedef enum logic [1:0] {ST_IDLE, ST_GNT0, ST_GNT1, ST_DRAIN} state_e;

  localparam bit                FIXED0  = (PRIORITY == "FIXED0");
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic [TO_WIDTH-1:0] wd_cnt_q, wd_cnt_d;

  logic       own;
  logic       own_cyc, own_stb, own_we, oth_cyc;
  logic [7:0] own_adr, own_dat;
  logic       wd_fire;

  assign own     = (state_q == ST_GNT1);
  assign own_cyc = own ? m1_cyc_i : m0_cyc_i;
  assign own_stb = own ? m1_stb_i : m0_stb_i;
  assign own_we  = own ? m1_we_i  : m0_we_i;
  assign own_adr = own ? m1_adr_i : m0_adr_i;
  assign own_dat = own ? m1_dat_i : m0_dat_i;
  assign oth_cyc = own ? m0_cyc_i : m1_cyc_i;

  assign dbg_state_o = state_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wd_cnt_d     = '0;
    wd_fire      = 1'b0;
    s_cyc_o      = 1'b0;
    s_stb_o      = 1'b0;
    s_we_o       = 1'b0;
    s_adr_o      = 8'h00;
    s_dat_o      = 8'h00;
    m0_dat_o     = 8'h00;
    m0_ack_o     = 1'b0;
    m0_err_o     = 1'b0;
    m1_dat_o     = 8'h00;
    m1_ack_o     = 1'b0;
    m1_err_o     = 1'b0;
    grant_o      = 2'b00;
    timeout_o    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = (FIXED0 || last_grant_q) ? ST_GNT0 : ST_GNT1;
        end else if (m0_cyc_i) begin
          state_d = ST_GNT0;
        end else if (m1_cyc_i) begin
          state_d = ST_GNT1;
        end
      end

      ST_GNT0, ST_GNT1: begin
        grant_o = own ? 2'b10 : 2'b01;
        s_cyc_o = own_cyc;
        s_stb_o = own_stb;
        s_we_o  = own_we;
        s_adr_o = own_adr;
        s_dat_o = own_dat;
        // Release wins over the watchdog; hand over directly if the other master waits.
        if (!own_cyc) begin
          state_d = oth_cyc ? (own ? ST_GNT0 : ST_GNT1) : ST_IDLE;
        end else if (own_stb && !s_ack_i) begin
          if (wd_cnt_q == TO_LAST) begin
            wd_fire = 1'b1;
            state_d = ST_DRAIN;
          end else begin
            wd_cnt_d = wd_cnt_q + TO_WIDTH'(1);
          end
        end
        if (own) begin
          m1_dat_o = s_dat_i;
          m1_ack_o = s_ack_i & m1_cyc_i;
          m1_err_o = wd_fire;
        end else begin
          m0_dat_o = s_dat_i;
          m0_ack_o = s_ack_i & m0_cyc_i;
          m0_err_o = wd_fire;
        end
        timeout_o = wd_fire;
      end

      ST_DRAIN: begin
        // last_grant still names the master that timed out.
        if (!(last_grant_q ? m1_cyc_i : m0_cyc_i)) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_GNT0) last_grant_d = 1'b0;
    if (state_d == ST_GNT1) last_grant_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      wd_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wd_cnt_q     <= wd_cnt_d;
    end
  end

endmodule

// File: tb/tb_efb_wb_arbiter.sv
// Randomized scoreboard bench for efb_wb_arbiter: transaction queues per master and per slave
// owner, a grant-order model, and directed watchdog/reset scenarios.
module tb_efb_wb_arbiter;

  localparam int TO = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       m0_cyc_i, m0_stb_i, m0_we_i;
  logic [7:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic       m0_ack_o, m0_err_o;
  logic       m1_cyc_i, m1_stb_i, m1_we_i;
  logic [7:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic       m1_ack_o, m1_err_o;
  logic       s_cyc_o, s_stb_o, s_we_o;
  logic [7:0] s_adr_o, s_dat_o, s_dat_i;
  logic       s_ack_i;
  logic [1:0] grant_o, dbg_state_o;
  logic       timeout_o;

  efb_wb_arbiter #(.PRIORITY("RR"), .TIMEOUT(TO), .TO_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o), .timeout_o(timeout_o), .dbg_state_o(dbg_state_o)
  );

  // scoreboard state
  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  logic [7:0]  exp_q0[$], exp_q1[$];
  logic [16:0] slv_q0[$], slv_q1[$];
  logic [1:0]  gnt_q[$];
  bit gnt_chk_en = 1'b0;
  bit to_win = 1'b0;
  bit no_ack = 1'b0;
  int lat_fixed = -1;
  int last_model = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected event, expected none", name);
  endtask

  function automatic logic [7:0] rd_fn(input logic [7:0] a);
    return a ^ 8'hD5;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic drive(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [7:0] adr, input logic [7:0] dat);
    if (m == 0) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat;
    end
  endtask

  task automatic run_burst(input int m, input int n, input bit force_we);
    logic [7:0] a, d;
    logic       w;
    int         k;
    for (int i = 0; i < n; i++) begin
      a = 8'($urandom);
      d = 8'($urandom);
      w = force_we ? 1'b1 : 1'($urandom_range(0, 1));
      if (m == 0) begin
        exp_q0.push_back(rd_fn(a)); slv_q0.push_back({w, a, d});
      end else begin
        exp_q1.push_back(rd_fn(a)); slv_q1.push_back({w, a, d});
      end
      drive(m, 1'b1, 1'b1, w, a, d);
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!(m == 0 ? m0_ack_o : m1_ack_o) && k < 100);
      if (k >= 100) fail_evt($sformatf("ack_wait_m%0d", m));
      tick();
    end
    drive(m, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // Reference arbitration: contention goes to the master that did not own the bus last.
  task automatic run_round(input int n0, input int n1, input int mode, input bit we0);
    int first;
    if (mode == 0) begin
      first = (last_model == 1) ? 0 : 1;
      gnt_q.push_back(first == 0 ? 2'b01 : 2'b10);
      gnt_q.push_back(first == 0 ? 2'b10 : 2'b01);
      last_model = 1 - first;
      fork
        run_burst(0, n0, we0);
        run_burst(1, n1, 1'b0);
      join
    end else if (mode == 1) begin
      gnt_q.push_back(2'b01);
      last_model = 0;
      run_burst(0, n0, we0);
    end else begin
      gnt_q.push_back(2'b10);
      last_model = 1;
      run_burst(1, n1, 1'b0);
    end
    tick();
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_grant", grant_o, 2'b00);
    check("rst_s_cyc_stb", {s_cyc_o, s_stb_o}, 2'b00);
    check("rst_acks_errs", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, timeout_o}, 5'b0);
    tick();
    rst_n = 1'b1;
    last_model = 1;
  endtask

  // slave model: random or fixed ack latency, read data derived from the address
  int sl_cnt = 0;
  bit sl_busy = 1'b0;
  initial begin
    s_ack_i = 1'b0;
    s_dat_i = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      s_ack_i = 1'b0;
      s_dat_i = 8'($urandom);
      if (s_cyc_o && s_stb_o && !no_ack) begin
        if (!sl_busy) begin
          sl_busy = 1'b1;
          sl_cnt  = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 2));
        end
        if (sl_cnt == 0) begin
          s_ack_i = 1'b1;
          s_dat_i = rd_fn(s_adr_o);
          sl_busy = 1'b0;
        end else begin
          sl_cnt--;
        end
      end else begin
        sl_busy = 1'b0;
      end
    end
  end

  // monitor: pops expectations whenever the DUT presents an ack or a new grant
  logic [1:0] prev_gnt = 2'b00;
  logic [1:0] handoff_to = 2'b00;
  bit handoff_exp = 1'b0;
  always @(negedge clk) begin
    if (handoff_exp) check("handoff_no_bubble", grant_o, handoff_to);
    handoff_exp = rst_n && ((grant_o == 2'b01 && !m0_cyc_i && m1_cyc_i) ||
                            (grant_o == 2'b10 && !m1_cyc_i && m0_cyc_i));
    handoff_to  = (grant_o == 2'b01) ? 2'b10 : 2'b01;

    if (gnt_chk_en && grant_o != prev_gnt && grant_o != 2'b00) begin
      if (gnt_q.size() == 0) fail_evt("grant_order");
      else check("grant_order", grant_o, gnt_q.pop_front());
    end
    prev_gnt = grant_o;

    if (m0_ack_o) begin
      if (exp_q0.size() == 0) fail_evt("m0_ack");
      else check("m0_dat", m0_dat_o, exp_q0.pop_front());
      check("m0_ack_owner", grant_o, 2'b01);
    end
    if (m1_ack_o) begin
      if (exp_q1.size() == 0) fail_evt("m1_ack");
      else check("m1_dat", m1_dat_o, exp_q1.pop_front());
      check("m1_ack_owner", grant_o, 2'b10);
    end

    if (s_ack_i && s_cyc_o && s_stb_o) begin
      if (grant_o == 2'b01) begin
        if (slv_q0.size() == 0) fail_evt("s_bus_m0");
        else check("s_bus_m0", {s_we_o, s_adr_o, s_dat_o}, slv_q0.pop_front());
      end else if (grant_o == 2'b10) begin
        if (slv_q1.size() == 0) fail_evt("s_bus_m1");
        else check("s_bus_m1", {s_we_o, s_adr_o, s_dat_o}, slv_q1.pop_front());
      end else begin
        fail_evt("s_bus_no_owner");
      end
    end

    if (m0_err_o || m1_err_o || timeout_o) begin
      err_seen++;
      if (!to_win) fail_evt("spurious_err");
    end
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: got no finish, expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int k;
    int e0;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    apply_reset();

    // m0 single read, slave acks two cycles after the strobe
    lat_fixed = 2;
    exp_q0.push_back(8'hA5);
    slv_q0.push_back({1'b0, 8'h70, 8'h00});
    drive(0, 1'b1, 1'b1, 1'b0, 8'h70, 8'h00);
    @(negedge clk);
    check("t1_arb_latency", grant_o, 2'b00);
    @(negedge clk);
    check("t1_grant", grant_o, 2'b01);
    check("t1_s_adr", s_adr_o, 8'h70);
    k = 0;
    while (!m0_ack_o && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("t1_ack_seen", m0_ack_o, 1'b1);
    check("t1_m1_ack_quiet", m1_ack_o, 1'b0);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    lat_fixed = -1;
    repeat (2) tick();

    // contention after reset, alternation, held 4-byte write sequence
    apply_reset();
    tick();
    gnt_chk_en = 1'b1;
    run_round(2, 2, 0, 1'b0);
    run_round(1, 1, 0, 1'b0);
    run_round(4, 1, 0, 1'b1);
    for (int r = 0; r < 30; r++)
      run_round($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(0, 2), 1'b0);

    // ack on the final watchdog cycle still completes normally
    lat_fixed = TO - 1;
    e0 = err_seen;
    run_round(0, 1, 2, 1'b0);
    lat_fixed = -1;
    check("ack_at_timeout_no_err", err_seen - e0, 0);
    check("gnt_q_drained", gnt_q.size(), 0);
    gnt_chk_en = 1'b0;

    // watchdog: slave never acks m1
    to_win = 1'b1;
    no_ack = 1'b1;
    drive(1, 1'b1, 1'b1, 1'b0, 8'h33, 8'h44);
    @(negedge clk);
    check("to_arb", grant_o, 2'b00);
    for (int i = 1; i <= TO - 1; i++) begin
      @(negedge clk);
      check("to_no_early_err", {m1_err_o, timeout_o}, 2'b00);
    end
    @(negedge clk);
    check("to_err_pulse", {m0_err_o, m1_err_o, timeout_o}, 3'b011);
    tick();
    drive(0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    check("to_drain_s_cyc", s_cyc_o, 1'b0);
    check("to_drain_grant", grant_o, 2'b00);
    check("to_single_pulse", {m1_err_o, timeout_o}, 2'b00);
    repeat (2) begin
      @(negedge clk);
      check("to_drain_hold", grant_o, 2'b00);
    end
    tick();
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    check("to_drain_exit", grant_o, 2'b00);
    @(negedge clk);
    check("to_idle_gap", grant_o, 2'b00);
    @(negedge clk);
    check("to_m0_after_drain", grant_o, 2'b01);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    to_win = 1'b0;

    // reset asserted mid-transfer while m1 owns the bus
    drive(1, 1'b1, 1'b1, 1'b1, 8'h5C, 8'h3E);
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_pre_grant", grant_o, 2'b10);
    tick();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_grant", grant_o, 2'b00);
    check("rst_mid_s_bus", {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o}, 19'h0);
    check("rst_mid_m1_out", {m1_ack_o, m1_err_o, m1_dat_o, timeout_o}, 11'h0);
    tick();
    rst_n = 1'b1;
    drive(0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    check("rst_mid_arb_latency", grant_o, 2'b00);
    @(negedge clk);
    check("rst_mid_m0_first", grant_o, 2'b01);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) tick();
    no_ack = 1'b0;

    check("sb_empty", exp_q0.size() + exp_q1.size() + slv_q0.size() + slv_q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/efb_wb_arbiter.md
Name: efb_wb_arbiter

Overview:
- Two-master Wishbone arbiter that shares the single 8-bit EFB Wishbone slave port between requesters.
- Typical pairing: m0 is the UFM read sequencer, m1 is a UFM/config writer or a soft-CPU bridge.
- A grant is held for the master's whole cyc assertion, so multi-transfer EFB command sequences are never interleaved.
- Includes a stalled-ack watchdog that returns err to the owning master and frees the bus.

Parameters:
- PRIORITY, "RR", arbitration policy: "RR" = round-robin on contention; "FIXED0" = m0 always wins contention.
- TIMEOUT, 255, number of consecutive cycles with s_stb_o=1 and s_ack_i=0 before the watchdog fires. Legal range 2..65535.
- TO_WIDTH, 16, width of the watchdog counter. Must satisfy 2^TO_WIDTH > TIMEOUT.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  synchronous reset, active-low.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 Wishbone cycle, strobe and write enable.
- m0_adr_i  in  8  master 0 EFB register address.
- m0_dat_i  in  8  master 0 write data.
- m0_dat_o  out  8  read data to master 0.
- m0_ack_o  out  1  ack to master 0.
- m0_err_o  out  1  watchdog error to master 0.
- m1_*: ports identical to the m0_* set above, for master 1.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to EFB slave.
- s_adr_o  out  8  to EFB slave.
- s_dat_o  out  8  write data to EFB slave.
- s_dat_i  in  8  read data from EFB slave.
- s_ack_i  in  1  ack from EFB slave.
- grant_o  out  2  one-hot current owner; 2'b00 when idle.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- States: IDLE, GNT0, GNT1, DRAIN. The state register and last_grant register are the only sequential arbitration state.
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, last_grant=1 so that m0 wins the first contention, watchdog counter=0.
  - All outputs are 0 from the following edge onward, including mid-transaction.
- IDLE:
  - Only m0_cyc_i high -> GNT0.
  - Only m1_cyc_i high -> GNT1.
  - Both high with "RR" -> grant the master != last_grant.
  - Both high with "FIXED0" -> GNT0.
  - Arbitration latency: 1 cycle from cyc assertion to grant.
- GNTx:
  - s_cyc/stb/we/adr/dat_o are combinationally muxed from master x.
  - mx_dat_o = s_dat_i; mx_ack_o = s_ack_i & mx_cyc_i.
  - The non-granted master sees dat_o=0, ack_o=0, err_o=0.
  - last_grant is set to x on entry.
- Release (mx_cyc_i=0 while in GNTx):
  - If the other master's cyc is high in the same cycle -> go directly to GNTother, no idle bubble.
  - Otherwise -> IDLE.
  - The slave sees s_cyc_o=0 during the release cycle because of the combinational mux.
- Watchdog:
  - The counter increments each cycle in GNTx with s_stb_o=1 and s_ack_i=0.
  - It clears on s_ack_i, on s_stb_o=0, or on a state change.
  - When counter == TIMEOUT-1 and no ack arrives that cycle: mx_err_o=1 and timeout_o=1 for exactly that cycle, and next state = DRAIN.
- DRAIN:
  - All s_* outputs are 0; ack and err to both masters are 0.
  - Stay in DRAIN until the timed-out master drops cyc, then -> IDLE.
  - Contending requests are evaluated only in IDLE, so there is a guaranteed 1-cycle gap.
- Ack and watchdog in the same cycle: the ack wins, and no err is raised.
- grant_o: GNT0 = 2'b01, GNT1 = 2'b10, IDLE and DRAIN = 2'b00.
- Starvation bound:
  - With "RR", a waiting master is granted within one full transaction of the other master plus 1 cycle.
  - "FIXED0" provides no starvation bound for m1.

Test Plan:
- Reset then m0 single read: m0_cyc_i=m0_stb_i=1, adr=8'h70, slave acks 2 cycles later with s_dat_i=8'hA5 -> grant_o=01 one cycle after the request, s_adr_o=8'h70, m0_dat_o=8'hA5 with m0_ack_o=1, m1_ack_o stays 0.
- Simultaneous requests after reset under "RR" -> m0 is granted first. m1 is granted in the cycle m0 drops cyc, with no IDLE bubble. The next contention grants m0 (alternation).
- m0 holds cyc across a 4-byte write sequence while m1 requests -> s_adr_o/s_dat_o show only m0 traffic until m0 releases, then grant_o=10.
- TIMEOUT=4, slave never acks m1's stb -> m1_err_o and timeout_o pulse once on the 4th stalled cycle, s_cyc_o=0 next cycle, state stays in DRAIN until m1_cyc_i=0, then m0 can be granted.
- Ack arriving on cycle TIMEOUT exactly -> no err, normal ack delivered.
- rst_n=0 asserted mid-transfer in GNT1 -> next cycle all outputs are 0, grant_o=00; after release of reset, contention grants m0 first.
